// File: rtl/out_buffer_writer.sv
// Stream-to-RAM writer: takes one frame of signed samples, shifts and saturates each
// to 16 bits, and writes them sequentially into the output buffer's write port.
module out_buffer_writer #(
    parameter int FRAME_LEN = 768,
    parameter int ADDR_BITS = 10,
    parameter int IN_WIDTH  = 24,
    parameter int SHIFT     = 8
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic [ADDR_BITS-1:0] Outa,
    output logic [15:0]          Outd,
    output logic                 OutBufWea,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           clip_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'(32767);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = IN_WIDTH'(-32768);
    localparam logic [ADDR_BITS-1:0]       LAST_ADDR = ADDR_BITS'(FRAME_LEN - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [ADDR_BITS-1:0]  r_outa;
    logic [15:0]           r_outd;
    logic                  r_we;
    logic [7:0]            r_clip;

    logic                  w_accept;
    logic                  w_last;
    logic signed [IN_WIDTH-1:0] w_shifted;
    logic                  w_hi;
    logic                  w_lo;
    logic [15:0]           w_sat;

    // Acceptance is decided from state alone so in_ready never depends on in_valid.
    assign w_accept  = in_valid && (r_state == S_WRITE);
    assign w_last    = (r_addr == LAST_ADDR);

    assign w_shifted = $signed(in_data) >>> SHIFT;
    assign w_hi      = (w_shifted > SAT_MAX);
    assign w_lo      = (w_shifted < SAT_MIN);
    assign w_sat     = w_hi ? 16'h7FFF : (w_lo ? 16'h8000 : w_shifted[15:0]);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Write port and counters: the final write lands in the DONE cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_addr <= '0;
            r_outa <= '0;
            r_outd <= '0;
            r_we   <= 1'b0;
            r_clip <= '0;
        end else begin
            r_we <= w_accept;
            if ((r_state == S_IDLE) && start) begin
                r_addr <= '0;
                r_clip <= '0;
            end
            if (w_accept) begin
                r_outa <= r_addr;
                r_outd <= w_sat;
                r_addr <= w_last ? '0 : r_addr + ADDR_BITS'(1);
                if ((w_hi || w_lo) && (r_clip != 8'hFF)) begin
                    r_clip <= r_clip + 8'd1;
                end
            end
        end
    end

    assign Outa       = r_outa;
    assign Outd       = r_outd;
    assign OutBufWea  = r_we;
    assign clip_count = r_clip;

endmodule
